align_scheduler: RTL and testbench

ALIGN_SCHEDULER -- requirements
Module: align_scheduler

---
 rtl/align_pkg.sv | 12 +
 rtl/align_scheduler_wavefront_skew.sv | 23 ++
 rtl/align_scheduler.sv | 141 ++++++++++++++
 tb/tb_align_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/align_pkg.sv
// Shared types and constants for the alignment scheduler and its helpers.
package align_pkg;
  localparam int DATA_W_DEFAULT = 32;
  localparam int TIMEOUT_MARGIN = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/align_scheduler_wavefront_skew.sv
// Sticky shift-in-ones enable: after load, one more PE column is enabled per shift cycle.
module wavefront_skew #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic         clear,
  output logic [M-1:0] start
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      start <= '0;
    end else if (load) begin
      start <= M'(1);
    end else if (shift) begin
      start <= (start << 1) | M'(1);
    end
  end

endmodule

// File: rtl/align_scheduler.sv
// Drives one systolic alignment run: clears the PE row, skews column starts, feeds PE 0 boundaries
// and captures the final score from the last column, with a cycle-bound timeout.
module align_scheduler
  import align_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] gap_penalty,
  output logic              pe_reset,
  output logic [M-1:0]      pe_start,
  input  logic [M-1:0]      pe_done,
  input  logic [M-1:0]      pe_finish,
  input  logic [DATA_W-1:0] pe_last_right,
  output logic [DATA_W-1:0] boundary_left,
  output logic [DATA_W-1:0] boundary_diag,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_score,
  output logic              timeout_err
);

  localparam int RUN_LIMIT = N + M + TIMEOUT_MARGIN;
  localparam int T_W       = $clog2(RUN_LIMIT + 1);
  localparam int C_W       = $clog2(N + 1);

  state_t            state, state_next;
  logic [T_W-1:0]    t_cnt;
  logic [C_W-1:0]    done_cnt;
  logic [DATA_W-1:0] gap_q;
  logic              last_row_done;
  logic              run_abort;
  logic              skew_load;
  logic              skew_shift;
  logic              skew_clear;
  logic              unused_cols;

  // Columns other than the last are observed only; their pulses do not steer the run.
  assign unused_cols = ^pe_done;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    pe_reset      = reset;
    busy          = 1'b1;
    result_valid  = 1'b0;
    last_row_done = 1'b0;
    run_abort     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = CLEAR;
      end
      CLEAR: begin
        pe_reset   = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        // A completing last row takes priority over a timeout in the same cycle.
        if (pe_done[M-1] && done_cnt == C_W'(N - 1)) begin
          last_row_done = 1'b1;
          state_next    = DONE;
        end else if (t_cnt == T_W'(RUN_LIMIT - 1) || (&pe_finish)) begin
          run_abort  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign skew_load  = (state == CLEAR);
  assign skew_shift = (state == RUN) && (state_next == RUN);
  assign skew_clear = !skew_load && !skew_shift;

  wavefront_skew #(.M(M)) u_skew (
    .clk   (clk),
    .reset (reset),
    .load  (skew_load),
    .shift (skew_shift),
    .clear (skew_clear),
    .start (pe_start)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q         <= '0;
      boundary_left <= '0;
      boundary_diag <= '0;
      t_cnt         <= '0;
      done_cnt      <= '0;
      result_score  <= '0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            gap_q       <= gap_penalty;
            timeout_err <= 1'b0;
          end
        end
        CLEAR: begin
          boundary_diag <= '0;
          boundary_left <= gap_q;
          t_cnt         <= '0;
          done_cnt      <= '0;
        end
        RUN: begin
          // Row r boundaries are r*gap and (r+1)*gap, built incrementally with wrap.
          t_cnt         <= t_cnt + T_W'(1);
          boundary_diag <= boundary_diag + gap_q;
          boundary_left <= boundary_left + gap_q;
          if (pe_done[M-1]) done_cnt <= done_cnt + C_W'(1);
          if (last_row_done) begin
            result_score <= pe_last_right;
          end else if (run_abort) begin
            result_score <= '0;
            timeout_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_align_scheduler.sv
// Randomized scoreboard bench for align_scheduler with a behavioural PE-row model.
module tb_align_scheduler;
  import align_pkg::*;

  localparam int N      = 4;
  localparam int M      = 4;
  localparam int DW     = 32;
  localparam int LAT_OK = N + M - 1;
  localparam int LAT_TO = N + M + TIMEOUT_MARGIN;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] gap_penalty;
  logic          pe_reset;
  logic [M-1:0]  pe_start;
  logic [M-1:0]  pe_done;
  logic [M-1:0]  pe_finish;
  logic [DW-1:0] pe_last_right;
  logic [DW-1:0] boundary_left;
  logic [DW-1:0] boundary_diag;
  logic          busy;
  logic          result_valid;
  logic [DW-1:0] result_score;
  logic          timeout_err;

  typedef struct {
    logic [DW-1:0] score;
    logic          to;
    int            lat;
    logic [DW-1:0] gap;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            mode     = 0;   // 0 normal, 1 last column silent, 2 all finished with no pulses
  logic [DW-1:0] row_score [N];
  int            pe_cnt [M];

  always #5 clk = ~clk;

  align_scheduler #(.N(N), .M(M), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .gap_penalty   (gap_penalty),
    .pe_reset      (pe_reset),
    .pe_start      (pe_start),
    .pe_done       (pe_done),
    .pe_finish     (pe_finish),
    .pe_last_right (pe_last_right),
    .boundary_left (boundary_left),
    .boundary_diag (boundary_diag),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_score  (result_score),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // PE row: each enabled column consumes one query row per cycle; finish is sticky after N rows.
  initial begin
    pe_done       = '0;
    pe_finish     = '0;
    pe_last_right = '0;
    for (int j = 0; j < M; j++) pe_cnt[j] = 0;
    forever begin
      @(negedge clk);
      if (pe_reset) begin
        pe_done   = '0;
        pe_finish = '0;
        for (int j = 0; j < M; j++) pe_cnt[j] = 0;
      end else begin
        pe_last_right = $urandom;
        for (int j = 0; j < M; j++) begin
          pe_finish[j] = (mode == 2) || (pe_cnt[j] >= N);
          pe_done[j]   = 1'b0;
          if (mode != 2 && pe_start[j] && pe_cnt[j] < N && !(mode == 1 && j == M - 1)) begin
            pe_done[j] = 1'b1;
            if (j == M - 1) pe_last_right = row_score[pe_cnt[j]];
            pe_cnt[j]++;
          end
        end
      end
    end
  end

  // Monitor: boundary values per row, handshake consistency, and result scoreboard.
  initial begin
    int            offset;
    bit            tracking;
    bit            prev_s0;
    exp_t          e;
    logic [DW-1:0] eb;
    offset   = 0;
    tracking = 0;
    prev_s0  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        tracking = 0;
        prev_s0  = 0;
      end else begin
        if (pe_start[0] && !prev_s0) begin
          tracking = 1;
          offset   = 0;
        end else if (tracking) begin
          offset++;
        end
        prev_s0 = pe_start[0];
        if (pe_start[0] && offset < N && exp_q.size() > 0) begin
          eb = DW'(exp_q[0].gap * DW'(offset + 1));
          check("boundary_left", boundary_left, eb);
          eb = DW'(exp_q[0].gap * DW'(offset));
          check("boundary_diag", boundary_diag, eb);
        end
        check("cmd_ready_vs_busy", cmd_ready, !busy);
        if (result_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got result_valid with score %0h, expected none", result_score);
          end else begin
            e = exp_q.pop_front();
            check("result_score", result_score, e.score);
            check("result_timeout", timeout_err, e.to);
            check("result_latency", offset, e.lat);
            check("done_pe_start", pe_start, '0);
          end
          tracking = 0;
        end
      end
    end
  end

  task automatic wait_accept(input logic [DW-1:0] g);
    int   k;
    exp_t e;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!busy && k < 50);
    check("accept", busy, 1);
    check("clear_pe_reset", pe_reset, 1);
    check("accept_clears_timeout", timeout_err, 0);
    e.gap   = g;
    e.to    = (mode != 0);
    e.score = (mode == 0) ? row_score[N-1] : '0;
    e.lat   = (mode == 0) ? LAT_OK : ((mode == 1) ? LAT_TO : 1);
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 100);
    check("run_completes", busy, 0);
  endtask

  task automatic set_scores(input int md, input logic [DW-1:0] final_sc);
    mode = md;
    for (int r = 0; r < N; r++) row_score[r] = $urandom;
    row_score[N-1] = final_sc;
  endtask

  task automatic issue(input logic [DW-1:0] g, input int md, input logic [DW-1:0] final_sc);
    set_scores(md, final_sc);
    @(negedge clk);
    gap_penalty = g;
    cmd_valid   = 1'b1;
    wait_accept(g);
    cmd_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            k;
    logic [DW-1:0] g;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    gap_penalty = '0;
    for (int r = 0; r < N; r++) row_score[r] = '0;
    repeat (3) @(negedge clk);
    check("rst_pe_reset", pe_reset, 1);
    check("rst_pe_start", pe_start, 0);
    check("rst_boundary_left", boundary_left, 0);
    check("rst_boundary_diag", boundary_diag, 0);
    check("rst_busy", busy, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_score", result_score, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Command coinciding with reset is dropped.
    reset       = 1'b1;
    cmd_valid   = 1'b1;
    gap_penalty = 32'h5;
    @(negedge clk);
    cmd_valid = 1'b0;
    reset     = 1'b0;
    check("reset_wins_busy", busy, 0);
    @(negedge clk);
    check("reset_wins_still_idle", busy, 0);

    issue(32'hFFFF_FFFF, 0, 32'd3);
    issue(32'hFFFF_FFFE, 0, $urandom);
    issue($urandom, 1, $urandom);
    check("timeout_sticky", timeout_err, 1);
    issue($urandom, 2, $urandom);

    // Reset in the middle of a run at t=3.
    set_scores(0, $urandom);
    g = $urandom;
    @(negedge clk);
    gap_penalty = g;
    cmd_valid   = 1'b1;
    wait_accept(g);
    cmd_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (pe_start != {M{1'b1}} && k < 50);
    check("reach_t3", pe_start, {M{1'b1}});
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrun_rst_pe_start", pe_start, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_no_result", result_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    issue($urandom, 0, $urandom);

    // Command held high: one run per IDLE visit.
    set_scores(0, $urandom);
    g = $urandom;
    @(negedge clk);
    gap_penalty = g;
    cmd_valid   = 1'b1;
    wait_accept(g);
    wait_idle();
    wait_accept(g);
    cmd_valid = 1'b0;
    wait_idle();

    issue(32'h8000_0000, 0, $urandom);
    for (int i = 0; i < 4; i++) issue($urandom, 0, $urandom);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
